// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the core's inst and data sram-like ports onto one AXI3 master.
// Ports: clk/resetn (async active-low); inst_sram_* and data_sram_* request/response
// ports from the core; ar*/r* read channels, aw*/w*/b* write channels towards AXI.
// Reads: fixed priority (data over inst), up to RD_DEPTH outstanding per port,
// responses steered by rid. Writes: data port only, AW and W complete independently.
module sram_axi_bridge #(
    parameter int         RD_DEPTH = 2,
    parameter logic [3:0] INST_ID  = 4'd0,
    parameter logic [3:0] DATA_ID  = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    localparam int CW = $clog2(RD_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(RD_DEPTH);

    typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_WAIT_B} w_state_t;

    ar_state_t     ar_state_q, ar_state_d;
    w_state_t      w_state_q, w_state_d;
    logic          live_q;
    logic [CW-1:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
    logic [3:0]    arid_q, arid_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [2:0]    arsize_q, arsize_d;
    logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [2:0]    awsize_q, awsize_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic          grant_d, grant_i, w_accept, r_data, r_inst, b_fire;
    logic          unused_inputs;

    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, bresp, bid};

    // live_q gates every handshake so nothing is accepted or reported while in reset
    assign grant_d  = live_q && ar_state_q == AR_IDLE && data_sram_req && !data_sram_wr
                   && dcnt_q < DEPTH && w_state_q == W_IDLE;
    assign grant_i  = live_q && ar_state_q == AR_IDLE && inst_sram_req && icnt_q < DEPTH && !grant_d;
    // a write waits for all data reads to retire so data responses stay in request order
    assign w_accept = live_q && w_state_q == W_IDLE && data_sram_req && data_sram_wr
                   && dcnt_q == '0 && !grant_d;
    assign r_data   = live_q && rvalid && rlast && rid == DATA_ID;
    assign r_inst   = live_q && rvalid && rlast && rid != DATA_ID;
    assign b_fire   = live_q && w_state_q == W_WAIT_B && bvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state_q <= AR_IDLE;
            w_state_q  <= W_IDLE;
            live_q     <= 1'b0;
            icnt_q     <= '0;
            dcnt_q     <= '0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arsize_q   <= '0;
            awaddr_q   <= '0;
            awsize_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            ar_state_q <= ar_state_d;
            w_state_q  <= w_state_d;
            live_q     <= 1'b1;
            icnt_q     <= icnt_d;
            dcnt_q     <= dcnt_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arsize_q   <= arsize_d;
            awaddr_q   <= awaddr_d;
            awsize_q   <= awsize_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        aw_done_d  = !w_accept && (aw_done_q || (awvalid && awready));
        w_done_d   = !w_accept && (w_done_q || (wvalid && wready));
        ar_state_d = (grant_d || grant_i) ? AR_SEND : (ar_state_q == AR_SEND && arready) ? AR_IDLE : ar_state_q;
        w_state_d  = w_accept ? W_SEND
                   : (w_state_q == W_SEND && aw_done_d && w_done_d) ? W_WAIT_B
                   : b_fire ? W_IDLE : w_state_q;
        // same-cycle increment and decrement cancel; the guard keeps a stray response from wrapping
        icnt_d     = icnt_q + CW'(grant_i) - CW'(r_inst && icnt_q != '0);
        dcnt_d     = dcnt_q + CW'(grant_d) - CW'(r_data && dcnt_q != '0);
        arid_d     = grant_d ? DATA_ID : grant_i ? INST_ID : arid_q;
        araddr_d   = grant_d ? data_sram_addr : grant_i ? inst_sram_addr : araddr_q;
        arsize_d   = grant_d ? {1'b0, data_sram_size} : grant_i ? {1'b0, inst_sram_size} : arsize_q;
        awaddr_d   = w_accept ? data_sram_addr : awaddr_q;
        awsize_d   = w_accept ? {1'b0, data_sram_size} : awsize_q;
        wdata_d    = w_accept ? data_sram_wdata : wdata_q;
        wstrb_d    = w_accept ? data_sram_wstrb : wstrb_q;
    end

    always_comb begin
        inst_sram_addr_ok = grant_i;
        inst_sram_data_ok = r_inst;
        inst_sram_rdata   = rdata;
        data_sram_addr_ok = grant_d || w_accept;
        data_sram_data_ok = r_data || b_fire;
        data_sram_rdata   = rdata;
        arid    = arid_q;
        araddr  = araddr_q;
        arlen   = 8'd0;
        arsize  = arsize_q;
        arburst = 2'b01;
        arlock  = 2'b00;
        arcache = 4'd0;
        arprot  = 3'd0;
        arvalid = ar_state_q == AR_SEND;
        rready  = live_q;
        awid    = DATA_ID;
        awaddr  = awaddr_q;
        awlen   = 8'd0;
        awsize  = awsize_q;
        awburst = 2'b01;
        awlock  = 2'b00;
        awcache = 4'd0;
        awprot  = 3'd0;
        awvalid = w_state_q == W_SEND && !aw_done_q;
        wid     = DATA_ID;
        wdata   = wdata_q;
        wstrb   = wstrb_q;
        wlast   = 1'b1;
        wvalid  = w_state_q == W_SEND && !w_done_q;
        bready  = live_q;
    end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the two sram-like master ports of the CPU core (instruction port, data port) into a single AXI3 master interface. It sits between the core top and the AXI interconnect. Its parametrised generalisations are:
- `RD_DEPTH` outstanding reads per master.
- Fixed-priority read arbitration.
- In-order response steering by AXI ID.
- An independent write path with AW/W decoupling.

## Interface
Parameters:
- `RD_DEPTH`, default 2: maximum outstanding reads per master (1–4).
- `INST_ID`, default 0: arid used for instruction-port reads.
- `DATA_ID`, default 1: arid/awid/wid used for data-port accesses.

Clock and reset are decided: one clock; `resetn` is asynchronous and active-low.

Ports:
- `clk` in 1: sole clock.
- `resetn` in 1: asynchronous active-low reset.
- `inst_sram_req`, `inst_sram_wr` in 1 each: request valid, write flag. Writes are unsupported; `wr` is ignored.
- `inst_sram_size` in 2, `inst_sram_wstrb` in 4, `inst_sram_addr` in 32, `inst_sram_wdata` in 32: request payload.
- `inst_sram_addr_ok`, `inst_sram_data_ok` out 1 each; `inst_sram_rdata` out 32.
- `data_sram_req`, `data_sram_wr` in 1 each; `data_sram_size` in 2, `data_sram_wstrb` in 4, `data_sram_addr` in 32, `data_sram_wdata` in 32.
- `data_sram_addr_ok`, `data_sram_data_ok` out 1 each; `data_sram_rdata` out 32.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst`/`arlock` out 2 each, `arcache`/`arprot` out 4/3, `arvalid` out 1, `arready` in 1.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- `awid` out 4, `awaddr` out 32, `awlen`/`awsize`/`awburst`/`awlock`/`awcache`/`awprot` out (same widths as AR), `awvalid` out 1, `awready` in 1.
- `wid` out 4, `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
Constant AXI fields:
- `arlen` = `awlen` = 0.
- `arburst` = `awburst` = 2'b01.
- lock, cache and prot are all 0.
- `wlast` = 1.
- `awid` = `wid` = `DATA_ID`.
- `arsize` / `awsize` = {1'b0, size}.

AR FSM, states `AR_IDLE` and `AR_SEND`:
- In `AR_IDLE`, a read is accepted when both hold:
  - `rd_cnt[port] < RD_DEPTH`;
  - for the data port, no write is outstanding.
- Data port has priority over instruction port.
- `addr_ok` is asserted to the winner only.
- On acceptance: latch addr/size/id into the AR registers, go to `AR_SEND`, `rd_cnt[port]++`.
- In `AR_SEND`: `arvalid` = 1. On `arvalid & arready`, return to `AR_IDLE`. No acceptance occurs in `AR_SEND`.

W FSM, states `W_IDLE`, `W_SEND`, `W_WAIT_B`:
- In `W_IDLE`, a data write (`data_sram_req & wr`) is accepted when `rd_cnt[data] == 0` and the AR FSM is not granting the data port that cycle. This serialises the data port so its responses stay in request order.
- On acceptance: `data_sram_addr_ok` = 1; latch addr/size/wdata/wstrb; `aw_done` = `w_done` = 0; go to `W_SEND`.
- In `W_SEND`: `awvalid` = !`aw_done`, `wvalid` = !`w_done`. Each flag sets on its own handshake. Same-cycle and either-order handshakes are all legal. When both are done, go to `W_WAIT_B`.
- In `W_WAIT_B`: on `bvalid & bready`, pulse `data_sram_data_ok` and go to `W_IDLE`.

R channel:
- `rready` = 1 out of reset.
- On `rvalid & rlast`:
  - if `rid == DATA_ID`: `data_sram_data_ok` = 1, `data_sram_rdata` = `rdata`, `rd_cnt[data]--`;
  - else: route to the instruction port the same way.
- `rdata` passes through combinationally to both `*_sram_rdata`.

Counter rules:
- Width is clog2(`RD_DEPTH`+1).
- Increment and decrement in the same cycle leave the count unchanged.
- Never wraps. Exceeding `RD_DEPTH` is prevented by the accept condition.

Other rules:
- `bready` = 1 out of reset.
- Nonzero `rresp`/`bresp` is ignored.

## Timing
- `addr_ok` is combinational from req and state (same cycle as req). All AXI valids are registered.
- Minimum read: req/`addr_ok` at cycle 0; `arvalid` at cycle 1; with zero-wait `arready` and `rvalid` at cycle 2, `data_ok` is at cycle 2.
- Back-to-back reads: the next acceptance occurs no earlier than the cycle after the AR handshake. Sustained rate is one read per 2 cycles.
- Write: `addr_ok` at cycle 0; `awvalid` and `wvalid` at cycle 1; `data_ok` in the `bvalid` cycle (cycle 2 or later).
- Reset (async, any time):
  - FSMs go to IDLE; counters to 0.
  - `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `addr_ok`, `data_ok` are all 0.
  - Payload registers go to 0.
  - In-flight transactions are abandoned. The bench must not return stale R/B responses after reset.
- Simultaneous data-read and inst-read requests: data wins; the inst port retries the next time the AR FSM is in `AR_IDLE`.

## Test plan
- Single inst read: addr 0x1C000000 with `arready` = 1 and `rdata` 0x02800C0C one cycle later. Required: `inst_sram_addr_ok` at cycle 0, `arvalid` at cycle 1, `inst_sram_data_ok` and rdata 0x02800C0C at cycle 2.
- Contention: inst and data reads issued in the same cycle. Required: data `addr_ok` first with `arid` = 1; inst `addr_ok` two cycles later with `arid` = 0. R responses returned in either order are each steered to the correct port.
- Depth limit (`RD_DEPTH` = 2): three inst reads with R withheld. Required: the third gets no `addr_ok` until the first `rvalid`/`rlast`, then is accepted.
- Write with AW/W skew: `awready` at cycle 1, `wready` at cycle 4, bvalid at cycle 6. Required: `awvalid` drops after cycle 1, `wvalid` is held through cycle 4, `data_sram_data_ok` at cycle 6.
- Ordering: data read outstanding, then a data write request. Required: the write gets no `addr_ok` until the read's `data_ok`. Conversely, a read request during `W_WAIT_B` is held until B.
- Reset mid-write (`resetn` low during `W_SEND`). Required: all valids 0 asynchronously, and after release the FSM is in `W_IDLE` with counters 0.
